// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and memory-owner encodings.
package dmem_arb_pkg;

  typedef enum logic {
    PIPE_OWN   = 1'b0,
    EXT_FORCED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_E    = 2'd2
  } owner_t;

  localparam logic [3:0]  WAIT_CNT_MAX  = 4'hF;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arbiter: pipeline port, external port, memory side and debug taps.
interface dmem_arb_if #(
  parameter int ADDRESS_LINE = 8,
  parameter int DATA_WIDTH   = 8
);
  import dmem_arb_pkg::*;

  // Handshake: port E holds ext_req/ext_we/ext_addr/ext_wdata stable until the cycle
  // ext_gnt=1; that cycle is the access. A read returns ext_rdata with a one-cycle
  // ext_rvalid pulse on the following cycle. Port P never handshakes: pipe_stall=1
  // means its request was not served this cycle and must be repeated.
  logic                    pipe_mem_read;
  logic                    pipe_mem_write;
  logic [ADDRESS_LINE-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0]   pipe_wdata;
  logic [DATA_WIDTH-1:0]   pipe_rdata;
  logic                    pipe_stall;

  logic                    ext_req;
  logic                    ext_we;
  logic [ADDRESS_LINE-1:0] ext_addr;
  logic [DATA_WIDTH-1:0]   ext_wdata;
  logic                    ext_gnt;
  logic [DATA_WIDTH-1:0]   ext_rdata;
  logic                    ext_rvalid;

  logic [ADDRESS_LINE-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_write_data;
  logic                    mem_write;
  logic                    mem_read;
  logic [DATA_WIDTH-1:0]   mem_read_data;

  state_t                  dbg_state;
  logic [3:0]              dbg_wait_cnt;

  modport slave (
    input  pipe_mem_read, pipe_mem_write, pipe_addr, pipe_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_read_data,
    output pipe_rdata, pipe_stall,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_address, mem_write_data, mem_write, mem_read,
    output dbg_state, dbg_wait_cnt
  );

  modport master (
    output pipe_mem_read, pipe_mem_write, pipe_addr, pipe_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_read_data,
    input  pipe_rdata, pipe_stall,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_address, mem_write_data, mem_write, mem_read,
    input  dbg_state, dbg_wait_cnt
  );

endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of cycles port E has been denied; flags when the next cycle must be forced.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ext_req,
  input  logic       i_grant_e,
  output logic       o_force_next,
  output logic [3:0] o_wait_cnt
);

  localparam logic [4:0] LP_MAX_WAIT = 5'(MAX_WAIT);

  logic [3:0] r_cnt;
  logic [4:0] w_cnt_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (!i_ext_req || i_grant_e) begin
      r_cnt <= 4'd0;
    end else if (r_cnt != WAIT_CNT_MAX) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Compare in 5 bits so a saturated count of 15 plus one does not wrap.
  assign w_cnt_inc    = {1'b0, r_cnt} + 5'd1;
  assign o_force_next = i_ext_req && !i_grant_e && (w_cnt_inc >= LP_MAX_WAIT);
  assign o_wait_cnt   = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline port P has priority, external port E gets idle or forced slots.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_LINE = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_WAIT     = 4
) (
  input  logic       clock,
  input  logic       reset,
  dmem_arb_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  state_t r_state;
  state_t w_state_next;
  owner_t w_owner;

  logic                    w_pipe_req;
  logic                    w_grant_e;
  logic                    w_pipe_stall;
  logic                    w_force_next;
  logic [3:0]              w_wait_cnt;

  logic [ADDRESS_LINE-1:0] w_mem_address;
  logic [DATA_WIDTH-1:0]   w_mem_write_data;
  logic                    w_mem_write;
  logic                    w_mem_read;
  logic [DATA_WIDTH-1:0]   w_pipe_rdata;

  logic [DATA_WIDTH-1:0]   r_ext_rdata;
  logic                    r_ext_rvalid;

  assign w_pipe_req = bus.pipe_mem_read | bus.pipe_mem_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= PIPE_OWN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_owner      = OWN_NONE;
    case (r_state)
      PIPE_OWN: begin
        if (w_pipe_req)       w_owner = OWN_P;
        else if (bus.ext_req) w_owner = OWN_E;
        w_state_next = w_force_next ? EXT_FORCED : PIPE_OWN;
      end
      EXT_FORCED: begin
        w_owner      = OWN_E;
        w_state_next = PIPE_OWN;
      end
      default: begin
        w_owner      = OWN_NONE;
        w_state_next = PIPE_OWN;
      end
    endcase
    // Nobody touches memory while reset is held.
    if (reset) w_owner = OWN_NONE;
  end

  assign w_grant_e    = (w_owner == OWN_E);
  assign w_pipe_stall = !reset && (r_state == EXT_FORCED) && w_pipe_req;

  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clock        (clock),
    .reset        (reset),
    .i_ext_req    (bus.ext_req),
    .i_grant_e    (w_grant_e),
    .o_force_next (w_force_next),
    .o_wait_cnt   (w_wait_cnt)
  );

  always_comb begin
    w_mem_address    = '0;
    w_mem_write_data = '0;
    w_mem_write      = 1'b0;
    w_mem_read       = 1'b0;
    w_pipe_rdata     = '0;
    case (w_owner)
      OWN_P: begin
        w_mem_address    = bus.pipe_addr;
        w_mem_write_data = bus.pipe_wdata;
        w_mem_write      = bus.pipe_mem_write;
        // A simultaneous read+write request is treated as a write.
        w_mem_read       = bus.pipe_mem_read & ~bus.pipe_mem_write;
        w_pipe_rdata     = bus.mem_read_data;
      end
      OWN_E: begin
        w_mem_address    = bus.ext_addr;
        w_mem_write_data = bus.ext_wdata;
        w_mem_write      = bus.ext_we;
        w_mem_read       = ~bus.ext_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ext_rdata  <= '0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_ext_rvalid <= w_grant_e & ~bus.ext_we;
      if (w_grant_e && !bus.ext_we) r_ext_rdata <= bus.mem_read_data;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_pipe_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.mem_address    = w_mem_address;
  assign bus.mem_write_data = w_mem_write_data;
  assign bus.mem_write      = w_mem_write;
  assign bus.mem_read       = w_mem_read;
  assign bus.pipe_rdata     = w_pipe_rdata;
  assign bus.pipe_stall     = w_pipe_stall;
  assign bus.ext_gnt        = w_grant_e;
  assign bus.ext_rdata      = r_ext_rdata;
  assign bus.ext_rvalid     = r_ext_rvalid;
  assign bus.dbg_state      = r_state;
  assign bus.dbg_wait_cnt   = w_wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a slot model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  dmem_arb_if #(.ADDRESS_LINE(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  dmem_arbiter #(
    .ADDRESS_LINE (AW),
    .DATA_WIDTH   (DW),
    .MAX_WAIT     (MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Environment memory: combinational read, write at the clock edge, reloaded during reset.
  logic [DW-1:0] dmem    [256];
  logic [DW-1:0] ref_mem [256];
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] init_val(input int i);
    return 8'((i * 7 + 3) % 256);
  endfunction

  assign bus.mem_read_data = dmem[bus.mem_address];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
    end else if (bus.mem_write) begin
      dmem[bus.mem_address] <= bus.mem_write_data;
    end else if (pre_we) begin
      dmem[pre_addr] <= pre_data;
    end
  end

  task automatic drive_idle();
    bus.pipe_mem_read  = 1'b0;
    bus.pipe_mem_write = 1'b0;
    bus.pipe_addr      = '0;
    bus.pipe_wdata     = '0;
    bus.ext_req        = 1'b0;
    bus.ext_we         = 1'b0;
    bus.ext_addr       = '0;
    bus.ext_wdata      = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    bus.ext_req       = 1'b1;
    bus.pipe_mem_read = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.ext_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.ext_gnt); end
    checks++; if (bus.pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.pipe_stall); end
    checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.ext_rdata); end
    checks++; if (bus.dbg_state !== PIPE_OWN) begin failures++; $display("FAIL reset_state got=%b exp=0", bus.dbg_state); end
    checks++; if (bus.dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL reset_wait got=%0d exp=0", bus.dbg_wait_cnt); end
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_ctl got=%b%b exp=00", bus.mem_write, bus.mem_read); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    drive_idle();
    #1 reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_idle_read();
    mem_poke(8'h10, 8'hA5);
    bus.ext_req  = 1'b1;
    bus.ext_we   = 1'b0;
    bus.ext_addr = 8'h10;
    @(negedge clock);
    checks++; if (bus.ext_gnt !== 1'b1) begin failures++; $display("FAIL idle_read_gnt got=%b exp=1", bus.ext_gnt); end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 8'h10) begin failures++; $display("FAIL idle_read_mem got rd=%b addr=%h exp rd=1 addr=10", bus.mem_read, bus.mem_address); end
    next_cycle();
    drive_idle();
    @(negedge clock);
    checks++; if (bus.ext_rvalid !== 1'b1) begin failures++; $display("FAIL idle_read_rvalid got=%b exp=1", bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== 8'hA5) begin failures++; $display("FAIL idle_read_rdata got=%h exp=a5", bus.ext_rdata); end
    next_cycle();
    @(negedge clock);
    checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL idle_read_pulse got=%b exp=0", bus.ext_rvalid); end
    next_cycle();
  endtask

  task automatic test_forced_slot();
    bus.pipe_mem_read = 1'b1;
    bus.pipe_addr     = 8'h40;
    bus.ext_req       = 1'b1;
    bus.ext_we        = 1'b0;
    bus.ext_addr      = 8'h41;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++; if (bus.ext_gnt !== (c == 5)) begin failures++; $display("FAIL forced_gnt cycle=%0d got=%b exp=%b", c, bus.ext_gnt, (c == 5)); end
      checks++; if (bus.pipe_stall !== (c == 5)) begin failures++; $display("FAIL forced_stall cycle=%0d got=%b exp=%b", c, bus.pipe_stall, (c == 5)); end
      if (c == 5) begin
        checks++; if (bus.mem_address !== 8'h41 || bus.pipe_rdata !== 8'h00) begin failures++; $display("FAIL forced_mux got addr=%h prd=%h exp addr=41 prd=00", bus.mem_address, bus.pipe_rdata); end
      end
      if (c == 6) begin
        checks++; if (bus.mem_address !== 8'h40 || bus.pipe_rdata !== init_val(8'h40)) begin failures++; $display("FAIL after_forced_p got addr=%h prd=%h exp addr=40 prd=%h", bus.mem_address, bus.pipe_rdata, init_val(8'h40)); end
        checks++; if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== init_val(8'h41)) begin failures++; $display("FAIL forced_rdata got v=%b d=%h exp v=1 d=%h", bus.ext_rvalid, bus.ext_rdata, init_val(8'h41)); end
      end
      next_cycle();
      if (c == 5) bus.ext_req = 1'b0;
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_p_store();
    bus.pipe_mem_write = 1'b1;
    bus.pipe_addr      = 8'h20;
    bus.pipe_wdata     = 8'h3C;
    bus.ext_req        = 1'b1;
    bus.ext_we         = 1'b1;
    bus.ext_addr       = 8'h22;
    bus.ext_wdata      = 8'h77;
    @(negedge clock);
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL p_store_ctl got wr=%b rd=%b exp wr=1 rd=0", bus.mem_write, bus.mem_read); end
    checks++; if (bus.mem_address !== 8'h20 || bus.mem_write_data !== 8'h3C) begin failures++; $display("FAIL p_store_bus got addr=%h wd=%h exp addr=20 wd=3c", bus.mem_address, bus.mem_write_data); end
    checks++; if (bus.pipe_stall !== 1'b0 || bus.ext_gnt !== 1'b0) begin failures++; $display("FAIL p_store_arb got stall=%b gnt=%b exp 0 0", bus.pipe_stall, bus.ext_gnt); end
    next_cycle();
    bus.pipe_mem_write = 1'b0;
    @(negedge clock);
    checks++; if (bus.ext_gnt !== 1'b1 || bus.mem_address !== 8'h22) begin failures++; $display("FAIL p_store_e_idle got gnt=%b addr=%h exp gnt=1 addr=22", bus.ext_gnt, bus.mem_address); end
    next_cycle();
    drive_idle();
    bus.pipe_mem_read = 1'b1;
    bus.pipe_addr     = 8'h20;
    @(negedge clock);
    checks++; if (bus.pipe_rdata !== 8'h3C) begin failures++; $display("FAIL p_store_readback got=%h exp=3c", bus.pipe_rdata); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_ext_write_then_load();
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 8'h30;
    bus.ext_wdata = 8'h55;
    @(negedge clock);
    checks++; if (bus.ext_gnt !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_write_data !== 8'h55) begin failures++; $display("FAIL ext_write got gnt=%b wr=%b wd=%h exp 1 1 55", bus.ext_gnt, bus.mem_write, bus.mem_write_data); end
    next_cycle();
    drive_idle();
    bus.pipe_mem_read = 1'b1;
    bus.pipe_addr     = 8'h30;
    @(negedge clock);
    checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL ext_write_rvalid got=%b exp=0", bus.ext_rvalid); end
    checks++; if (bus.pipe_rdata !== 8'h55) begin failures++; $display("FAIL ext_write_load got=%h exp=55", bus.pipe_rdata); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_in_forced();
    bus.pipe_mem_read = 1'b1;
    bus.pipe_addr     = 8'h50;
    bus.ext_req       = 1'b1;
    bus.ext_addr      = 8'h51;
    repeat (4) next_cycle();
    @(negedge clock);
    checks++; if (bus.ext_gnt !== 1'b1 || bus.dbg_state !== EXT_FORCED) begin failures++; $display("FAIL pre_reset_forced got gnt=%b st=%b exp 1 1", bus.ext_gnt, bus.dbg_state); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.ext_gnt !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL async_reset_out got gnt=%b stall=%b rv=%b exp 0 0 0", bus.ext_gnt, bus.pipe_stall, bus.ext_rvalid); end
    drive_idle();
    next_cycle();
    #2 reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.dbg_state !== PIPE_OWN || bus.dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL post_reset got st=%b wait=%0d exp 0 0", bus.dbg_state, bus.dbg_wait_cnt); end
    next_cycle();
  endtask

  // Model: E is forced in once it has been denied MAX_WAIT consecutive cycles; otherwise P first, then E.
  task automatic test_random();
    bit            e_pend = 1'b0;
    int            waited = 0;
    bit            exp_rv = 1'b0;
    int            p_op;
    bit            forced;
    owner_t        own;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      p_op = $urandom_range(0, 9);
      bus.pipe_mem_read  = (p_op >= 3 && p_op < 7);
      bus.pipe_mem_write = (p_op >= 7);
      bus.pipe_addr      = 8'($urandom_range(0, 255));
      bus.pipe_wdata     = 8'($urandom_range(0, 255));
      if (!e_pend && $urandom_range(0, 2) == 0) begin
        e_pend        = 1'b1;
        bus.ext_we    = 1'($urandom_range(0, 1));
        bus.ext_addr  = 8'($urandom_range(0, 255));
        bus.ext_wdata = 8'($urandom_range(0, 255));
      end
      bus.ext_req = e_pend;
      forced = e_pend && (waited >= MW);
      if (forced)                                      own = OWN_E;
      else if (bus.pipe_mem_read || bus.pipe_mem_write) own = OWN_P;
      else if (e_pend)                                 own = OWN_E;
      else                                             own = OWN_NONE;
      @(negedge clock);
      checks++; if (bus.ext_gnt !== (own == OWN_E)) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.ext_gnt, (own == OWN_E)); end
      checks++; if (bus.pipe_stall !== (forced && (bus.pipe_mem_read || bus.pipe_mem_write))) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b", cyc, bus.pipe_stall); end
      checks++;
      case (own)
        OWN_P: if (bus.mem_address !== bus.pipe_addr || bus.mem_write !== bus.pipe_mem_write || bus.mem_read !== bus.pipe_mem_read || bus.mem_write_data !== bus.pipe_wdata || bus.pipe_rdata !== ref_mem[bus.pipe_addr]) begin
          failures++; $display("FAIL rnd_p_bus cyc=%0d got addr=%h wr=%b rd=%b prd=%h exp addr=%h prd=%h", cyc, bus.mem_address, bus.mem_write, bus.mem_read, bus.pipe_rdata, bus.pipe_addr, ref_mem[bus.pipe_addr]); end
        OWN_E: if (bus.mem_address !== bus.ext_addr || bus.mem_write !== bus.ext_we || bus.mem_read !== !bus.ext_we || bus.mem_write_data !== bus.ext_wdata || bus.pipe_rdata !== 8'h00) begin
          failures++; $display("FAIL rnd_e_bus cyc=%0d got addr=%h wr=%b rd=%b exp addr=%h wr=%b", cyc, bus.mem_address, bus.mem_write, bus.mem_read, bus.ext_addr, bus.ext_we); end
        default: if (bus.mem_address !== 8'h00 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write_data !== 8'h00) begin
          failures++; $display("FAIL rnd_idle_bus cyc=%0d got addr=%h wr=%b rd=%b exp 00 0 0", cyc, bus.mem_address, bus.mem_write, bus.mem_read); end
      endcase
      checks++; if (bus.ext_rvalid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.ext_rvalid, exp_rv); end
      if (exp_rv && exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        checks++; if (bus.ext_rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.ext_rdata, exp_rd); end
      end
      exp_rv = 1'b0;
      if (own == OWN_P && bus.pipe_mem_write) ref_mem[bus.pipe_addr] = bus.pipe_wdata;
      if (own == OWN_E) begin
        if (bus.ext_we) ref_mem[bus.ext_addr] = bus.ext_wdata;
        else begin exp_q.push_back(ref_mem[bus.ext_addr]); exp_rv = 1'b1; end
        e_pend = 1'b0;
        waited = 0;
      end else if (e_pend) begin
        waited++;
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    drive_idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.pipe_mem_read = 1'b1;
    bus.pipe_addr     = 8'h60;
    bus.ext_req       = 1'b1;
    bus.ext_addr      = 8'h61;
    repeat (15) next_cycle();
    drive_idle();
    @(negedge clock);
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL stats_stall_cnt got=%0d exp=3", stall_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_read();
    test_forced_slot();
    test_p_store();
    test_ext_write_then_load();
    test_reset_in_forced();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
